// File: rtl/ooo_pkg.sv
// Shared definitions for the out-of-order 6502 core's issue logic.
//   TAG_W_DEFAULT : default physical tag width
//   flag_bit_e    : 6502 status flag bit positions (as carried on cdb_value[7:0])
//   OP_UNCOND_BIT : opcode bit marking an unconditional terminate op (flags unused)
//   src_sel_e     : per-slot next-state source in the collapsing station
//   rs_payload_t  : per-slot operand/state payload (tags kept separate so the
//                   tag width can stay a module parameter)
package ooo_pkg;

  localparam int TAG_W_DEFAULT = 6;
  localparam int OP_UNCOND_BIT = 0;

  typedef enum int {
    FLAG_C = 0,
    FLAG_Z = 1,
    FLAG_I = 2,
    FLAG_D = 3,
    FLAG_B = 4,
    FLAG_V = 6,
    FLAG_N = 7
  } flag_bit_e;

  typedef enum logic [1:0] {
    SRC_HOLD  = 2'd0,
    SRC_UPPER = 2'd1,
    SRC_DISP  = 2'd2,
    SRC_CLEAR = 2'd3
  } src_sel_e;

  typedef struct packed {
    logic [3:0]  opcode;
    logic        base_rdy;
    logic [15:0] base_val;
    logic        flag_rdy;
    logic [7:0]  flag_val;
    logic [7:0]  offset;
    logic [3:0]  immediate;
  } rs_payload_t;

  // An unconditional op only needs its base operand.
  function automatic logic entry_ready(input logic valid, input rs_payload_t p);
    return valid & p.base_rdy & (p.opcode[OP_UNCOND_BIT] | p.flag_rdy);
  endfunction

endpackage

// File: rtl/terminate_station_if.sv
// Dispatch, result-broadcast and issue signals of the terminate reservation station.
//   master : the core side (dispatch unit, CDB, terminate pipeline)
//   slave  : the station
interface terminate_station_if #(
  parameter int TAG_W = ooo_pkg::TAG_W_DEFAULT
) ();
  logic              disp_valid;
  logic              disp_ready;
  logic [3:0]        disp_opcode;
  logic [TAG_W-1:0]  disp_base_tag;
  logic [TAG_W-1:0]  disp_flag_tag;
  logic              disp_base_rdy;
  logic              disp_flag_rdy;
  logic [15:0]       disp_base_val;
  logic [7:0]        disp_flag_val;
  logic [7:0]        disp_offset;
  logic [3:0]        disp_immediate;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [15:0]       cdb_value;

  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        opcode;
  logic [15:0]       reg_base_val;
  logic [7:0]        flag_vals;
  logic [7:0]        offset;
  logic [3:0]        immediate;

  modport master (
    output disp_valid, disp_opcode, disp_base_tag, disp_flag_tag, disp_base_rdy,
           disp_flag_rdy, disp_base_val, disp_flag_val, disp_offset, disp_immediate,
           cdb_valid, cdb_tag, cdb_value, instr_ready,
    input  disp_ready, instr_valid, opcode, reg_base_val, flag_vals, offset, immediate
  );

  modport slave (
    input  disp_valid, disp_opcode, disp_base_tag, disp_flag_tag, disp_base_rdy,
           disp_flag_rdy, disp_base_val, disp_flag_val, disp_offset, disp_immediate,
           cdb_valid, cdb_tag, cdb_value, instr_ready,
    output disp_ready, instr_valid, opcode, reg_base_val, flag_vals, offset, immediate
  );
endinterface

// File: rtl/terminate_station_entry.sv
// One slot of the collapsing terminate reservation station.
// Ports:
//   clk, rst_n        clock, async active-low reset (clears valid only)
//   src_sel           next-state source: hold / upper neighbour / dispatch / clear
//   up_*              contents of the next-younger slot (shift-down source)
//   disp_*            incoming dispatch op
//   cdb_*             result broadcast used for operand wakeup
//   valid_o, *_tag_o, pl_o, ready_o   current slot contents and issue readiness
module terminate_station_entry
  import ooo_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  src_sel_e          src_sel,
  input  logic              up_valid,
  input  logic [TAG_W-1:0]  up_base_tag,
  input  logic [TAG_W-1:0]  up_flag_tag,
  input  rs_payload_t       up_pl,
  input  logic [TAG_W-1:0]  disp_base_tag,
  input  logic [TAG_W-1:0]  disp_flag_tag,
  input  rs_payload_t       disp_pl,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [15:0]       cdb_value,
  output logic              valid_o,
  output logic [TAG_W-1:0]  base_tag_o,
  output logic [TAG_W-1:0]  flag_tag_o,
  output rs_payload_t       pl_o,
  output logic              ready_o
);

  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  base_tag_q, base_tag_d;
  logic [TAG_W-1:0]  flag_tag_q, flag_tag_d;
  rs_payload_t       pl_q, pl_d;

  always_comb begin
    valid_d    = valid_q;
    base_tag_d = base_tag_q;
    flag_tag_d = flag_tag_q;
    pl_d       = pl_q;
    case (src_sel)
      SRC_UPPER: begin
        valid_d    = up_valid;
        base_tag_d = up_base_tag;
        flag_tag_d = up_flag_tag;
        pl_d       = up_pl;
      end
      SRC_DISP: begin
        valid_d    = 1'b1;
        base_tag_d = disp_base_tag;
        flag_tag_d = disp_flag_tag;
        pl_d       = disp_pl;
      end
      SRC_CLEAR: valid_d = 1'b0;
      default: ;
    endcase
    // Wakeup is applied after the source mux, so a shifted-in entry wakes at its
    // new position and a dispatching op catches a same-cycle broadcast.
    if (cdb_valid && valid_d) begin
      if (!pl_d.base_rdy && (base_tag_d == cdb_tag)) begin
        pl_d.base_rdy = 1'b1;
        pl_d.base_val = cdb_value;
      end
      if (!pl_d.flag_rdy && (flag_tag_d == cdb_tag)) begin
        pl_d.flag_rdy = 1'b1;
        pl_d.flag_val = cdb_value[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  // Payload is only meaningful while valid, so it carries no reset.
  always_ff @(posedge clk) begin
    base_tag_q <= base_tag_d;
    flag_tag_q <= flag_tag_d;
    pl_q       <= pl_d;
  end

  assign valid_o    = valid_q;
  assign base_tag_o = base_tag_q;
  assign flag_tag_o = flag_tag_q;
  assign pl_o       = pl_q;
  assign ready_o    = entry_ready(valid_q, pl_q);

endmodule

// File: rtl/terminate_station.sv
// Reservation station feeding the terminate pipeline. Collapsing queue (slot 0
// oldest); dispatched ops wait for base/flag operands via CDB snooping and the
// oldest ready op is offered over a valid/ready handshake.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   flush  synchronous discard of all entries
//   bus    terminate_station_if.slave (dispatch, CDB, issue)
module terminate_station
  import ooo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  terminate_station_if.slave    bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]  count_q, count_d;

  // Slot DEPTH is a permanently empty phantom that the top slot shifts in from.
  logic [DEPTH:0]    ent_valid;
  logic [TAG_W-1:0]  ent_base_tag [DEPTH+1];
  logic [TAG_W-1:0]  ent_flag_tag [DEPTH+1];
  rs_payload_t       ent_pl       [DEPTH+1];
  logic [DEPTH-1:0]  ent_ready;
  src_sel_e          src_sel      [DEPTH];

  rs_payload_t       disp_pl, sel_pl;
  logic [IDX_W-1:0]  sel_idx;
  logic              any_ready, issue, disp_fire, disp_ready_w;
  logic [CNT_W-1:0]  wr_idx;

  assign ent_valid[DEPTH]    = 1'b0;
  assign ent_base_tag[DEPTH] = '0;
  assign ent_flag_tag[DEPTH] = '0;
  assign ent_pl[DEPTH]       = '0;

  assign disp_pl = '{opcode:    bus.disp_opcode,
                     base_rdy:  bus.disp_base_rdy,
                     base_val:  bus.disp_base_val,
                     flag_rdy:  bus.disp_flag_rdy,
                     flag_val:  bus.disp_flag_val,
                     offset:    bus.disp_offset,
                     immediate: bus.disp_immediate};

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    terminate_station_entry #(.TAG_W(TAG_W)) u_entry (
      .clk           (clk),
      .rst_n         (rst_n),
      .src_sel       (src_sel[g]),
      .up_valid      (ent_valid[g+1]),
      .up_base_tag   (ent_base_tag[g+1]),
      .up_flag_tag   (ent_flag_tag[g+1]),
      .up_pl         (ent_pl[g+1]),
      .disp_base_tag (bus.disp_base_tag),
      .disp_flag_tag (bus.disp_flag_tag),
      .disp_pl       (disp_pl),
      .cdb_valid     (bus.cdb_valid),
      .cdb_tag       (bus.cdb_tag),
      .cdb_value     (bus.cdb_value),
      .valid_o       (ent_valid[g]),
      .base_tag_o    (ent_base_tag[g]),
      .flag_tag_o    (ent_flag_tag[g]),
      .pl_o          (ent_pl[g]),
      .ready_o       (ent_ready[g])
    );
  end

  // Oldest-first select: scan from the top so the lowest ready index wins.
  always_comb begin
    sel_idx = '0;
    sel_pl  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_ready[i]) begin
        sel_idx = IDX_W'(i);
        sel_pl  = ent_pl[i];
      end
    end
  end

  assign any_ready    = |ent_ready;
  assign disp_ready_w = (count_q < CNT_W'(DEPTH));
  assign issue        = any_ready & bus.instr_ready & ~flush;
  assign disp_fire    = bus.disp_valid & disp_ready_w & ~flush;
  // Dispatch lands just above the survivors after this cycle's collapse.
  assign wr_idx       = count_q - CNT_W'(issue);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      src_sel[i] = SRC_HOLD;
      if (flush)
        src_sel[i] = SRC_CLEAR;
      else if (disp_fire && (CNT_W'(i) == wr_idx))
        src_sel[i] = SRC_DISP;
      else if (issue && (IDX_W'(i) >= sel_idx))
        src_sel[i] = SRC_UPPER;
    end
  end

  always_comb begin
    if (flush) count_d = '0;
    else       count_d = count_q - CNT_W'(issue) + CNT_W'(disp_fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign bus.disp_ready   = disp_ready_w;
  assign bus.instr_valid  = any_ready;
  assign bus.opcode       = sel_pl.opcode;
  assign bus.reg_base_val = sel_pl.base_val;
  assign bus.flag_vals    = sel_pl.flag_val;
  assign bus.offset       = sel_pl.offset;
  assign bus.immediate    = sel_pl.immediate;

endmodule

// File: tb/tb_terminate_station.sv
// Bench for terminate_station: directed scenarios plus a randomized run checked
// against a queue-based reference model of the station.
module tb_terminate_station;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  terminate_station_if #(.TAG_W(TAG_W)) bus ();
  terminate_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    bit [3:0] op; bit [5:0] bt; bit br; bit [15:0] bv;
    bit [5:0] ft; bit fr; bit [7:0] fv; bit [7:0] off; bit [3:0] imm;
  } m_ent_t;
  m_ent_t mq[$];

  function automatic int m_sel();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].br && (mq[i].op[0] || mq[i].fr)) return i;
    return -1;
  endfunction

  // Model of one clock edge from the current inputs.
  function automatic void model_step();
    int k;
    bit full;
    m_ent_t e;
    if (!rst_n || flush) begin mq.delete(); return; end
    k = m_sel();
    full = (mq.size() >= DEPTH);
    if (k >= 0 && bus.instr_ready) mq.delete(k);
    if (bus.disp_valid && !full) begin
      e.op = bus.disp_opcode; e.bt = bus.disp_base_tag; e.br = bus.disp_base_rdy;
      e.bv = bus.disp_base_val; e.ft = bus.disp_flag_tag; e.fr = bus.disp_flag_rdy;
      e.fv = bus.disp_flag_val; e.off = bus.disp_offset; e.imm = bus.disp_immediate;
      mq.push_back(e);
    end
    if (bus.cdb_valid) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (!mq[i].br && mq[i].bt == bus.cdb_tag) begin mq[i].br = 1; mq[i].bv = bus.cdb_value; end
        if (!mq[i].fr && mq[i].ft == bus.cdb_tag) begin mq[i].fr = 1; mq[i].fv = bus.cdb_value[7:0]; end
      end
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.disp_valid = 0; bus.disp_opcode = 0; bus.disp_base_tag = 0; bus.disp_flag_tag = 0;
    bus.disp_base_rdy = 0; bus.disp_flag_rdy = 0; bus.disp_base_val = 0; bus.disp_flag_val = 0;
    bus.disp_offset = 0; bus.disp_immediate = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_value = 0;
    bus.instr_ready = 0; flush = 0;
  endtask

  task automatic disp(input bit [3:0] op, input bit [5:0] bt, input bit br, input bit [15:0] bv,
                      input bit [5:0] ft, input bit fr, input bit [7:0] fv,
                      input bit [7:0] off, input bit [3:0] imm);
    bus.disp_valid = 1; bus.disp_opcode = op; bus.disp_base_tag = bt; bus.disp_base_rdy = br;
    bus.disp_base_val = bv; bus.disp_flag_tag = ft; bus.disp_flag_rdy = fr;
    bus.disp_flag_val = fv; bus.disp_offset = off; bus.disp_immediate = imm;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (bus.disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready: got %b want 1", bus.disp_ready); end
    n_chk++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid: got %b want 0", bus.instr_valid); end
    n_chk++; if ({bus.opcode, bus.reg_base_val, bus.flag_vals} !== 28'h0) begin n_fail++;
      $display("FAIL reset_data: got %h want 0", {bus.opcode, bus.reg_base_val, bus.flag_vals}); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    disp(4'h1, 6'd0, 1, 16'h1200, 6'd0, 0, 8'h00, 8'h10, 4'h3);
    @(negedge clk);
    n_chk++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_not_yet: got %b want 0", bus.instr_valid); end
    tick();
    idle();
    @(negedge clk);
    n_chk++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", bus.instr_valid); end
    n_chk++; if ({bus.opcode, bus.reg_base_val, bus.offset, bus.immediate} !== {4'h1, 16'h1200, 8'h10, 4'h3}) begin n_fail++;
      $display("FAIL basic_fields: got %h want %h", {bus.opcode, bus.reg_base_val, bus.offset, bus.immediate}, {4'h1, 16'h1200, 8'h10, 4'h3}); end
    bus.instr_ready = 1;
    tick();
    idle();
    @(negedge clk);
    n_chk++; if ({bus.instr_valid, bus.disp_ready} !== 2'b01) begin n_fail++;
      $display("FAIL basic_empty: got %b want 01", {bus.instr_valid, bus.disp_ready}); end
  endtask

  task automatic test_flag_wakeup();
    disp(4'h2, 6'd9, 1, 16'h3000, 6'd5, 0, 8'h00, 8'h11, 4'h0);
    tick();
    idle();
    bus.cdb_valid = 1; bus.cdb_tag = 6'd5; bus.cdb_value = 16'h0081;
    @(negedge clk);
    n_chk++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL flag_waiting: got %b want 0", bus.instr_valid); end
    tick();
    idle();
    @(negedge clk);
    n_chk++; if ({bus.instr_valid, bus.flag_vals} !== {1'b1, 8'h81}) begin n_fail++;
      $display("FAIL flag_woken: got %h want %h", {bus.instr_valid, bus.flag_vals}, {1'b1, 8'h81}); end
    bus.instr_ready = 1;
    tick();
    idle();
  endtask

  task automatic test_order();
    disp(4'h1, 6'd3, 0, 16'h0000, 6'd0, 0, 8'h00, 8'h0A, 4'h0);
    tick();
    disp(4'h1, 6'd0, 1, 16'h2222, 6'd0, 0, 8'h00, 8'h0B, 4'h0);
    tick();
    idle();
    @(negedge clk);
    n_chk++; if ({bus.instr_valid, bus.offset} !== {1'b1, 8'h0B}) begin n_fail++;
      $display("FAIL order_b_first: got %h want %h", {bus.instr_valid, bus.offset}, {1'b1, 8'h0B}); end
    bus.instr_ready = 1;
    tick();
    idle();
    @(negedge clk);
    n_chk++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL order_a_waits: got %b want 0", bus.instr_valid); end
    bus.cdb_valid = 1; bus.cdb_tag = 6'd3; bus.cdb_value = 16'h3333;
    tick();
    idle();
    @(negedge clk);
    n_chk++; if ({bus.instr_valid, bus.offset, bus.reg_base_val} !== {1'b1, 8'h0A, 16'h3333}) begin n_fail++;
      $display("FAIL order_a_second: got %h want %h", {bus.instr_valid, bus.offset, bus.reg_base_val}, {1'b1, 8'h0A, 16'h3333}); end
    bus.instr_ready = 1;
    tick();
    idle();
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      disp(4'h1, 6'd0, 1, 16'h4000 + 16'(i), 6'd0, 0, 8'h00, 8'h20 + 8'(i), 4'h0);
      tick();
    end
    disp(4'h1, 6'd0, 1, 16'h4444, 6'd0, 0, 8'h00, 8'h24, 4'h0);
    bus.instr_ready = 1;
    @(negedge clk);
    n_chk++; if ({bus.disp_ready, bus.instr_valid, bus.offset} !== {1'b0, 1'b1, 8'h20}) begin n_fail++;
      $display("FAIL full_refuse: got %h want %h", {bus.disp_ready, bus.instr_valid, bus.offset}, {1'b0, 1'b1, 8'h20}); end
    tick();
    idle();
    bus.instr_ready = 1;
    for (int j = 0; j < DEPTH - 1; j++) begin
      @(negedge clk);
      n_chk++; if ({bus.disp_ready, bus.instr_valid, bus.offset} !== {1'b1, 1'b1, 8'h21 + 8'(j)}) begin n_fail++;
        $display("FAIL full_drain%0d: got %h want %h", j, {bus.disp_ready, bus.instr_valid, bus.offset}, {1'b1, 1'b1, 8'h21 + 8'(j)}); end
      tick();
    end
    idle();
    @(negedge clk);
    n_chk++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL full_fifth_dropped: got %b want 0", bus.instr_valid); end
  endtask

  task automatic test_capture();
    disp(4'h1, 6'd7, 0, 16'h0000, 6'd0, 0, 8'h00, 8'h50, 4'h0);
    bus.cdb_valid = 1; bus.cdb_tag = 6'd7; bus.cdb_value = 16'hBEEF;
    tick();
    idle();
    @(negedge clk);
    n_chk++; if ({bus.instr_valid, bus.reg_base_val} !== {1'b1, 16'hBEEF}) begin n_fail++;
      $display("FAIL capture: got %h want %h", {bus.instr_valid, bus.reg_base_val}, {1'b1, 16'hBEEF}); end
    bus.instr_ready = 1;
    tick();
    idle();
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 3; i++) begin
      disp(4'h1, 6'd0, 1, 16'h5000, 6'd0, 0, 8'h00, 8'h30 + 8'(i), 4'h0);
      tick();
    end
    disp(4'h1, 6'd0, 1, 16'h5555, 6'd0, 0, 8'h00, 8'h3F, 4'h0);
    bus.instr_ready = 1; flush = 1;
    @(negedge clk);
    n_chk++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL flush_cycle_valid: got %b want 1", bus.instr_valid); end
    tick();
    idle();
    @(negedge clk);
    n_chk++; if ({bus.instr_valid, bus.disp_ready} !== 2'b01) begin n_fail++;
      $display("FAIL flush_empty: got %b want 01", {bus.instr_valid, bus.disp_ready}); end
    disp(4'h1, 6'd0, 1, 16'h6000, 6'd0, 0, 8'h00, 8'h40, 4'h0);
    tick();
    disp(4'h1, 6'd0, 1, 16'h6001, 6'd0, 0, 8'h00, 8'h41, 4'h0);
    tick();
    idle();
    @(negedge clk);
    n_chk++; if ({bus.instr_valid, bus.offset} !== {1'b1, 8'h40}) begin n_fail++;
      $display("FAIL flush_refill: got %h want %h", {bus.instr_valid, bus.offset}, {1'b1, 8'h40}); end
    #1 rst_n = 0;
    #1;
    n_chk++; if ({bus.instr_valid, bus.disp_ready} !== 2'b01) begin n_fail++;
      $display("FAIL async_reset: got %b want 01", {bus.instr_valid, bus.disp_ready}); end
    mq.delete();
    rst_n = 1;
    tick();
  endtask

  task automatic test_random();
    int k;
    bit [39:0] exp_f;
    flush = 1;
    tick();
    idle();
    for (int c = 0; c < 400; c++) begin
      bus.disp_valid = ($urandom_range(0, 9) < 6);
      bus.disp_opcode = 4'($urandom);
      bus.disp_base_tag = 6'($urandom_range(0, 7));
      bus.disp_flag_tag = 6'($urandom_range(0, 7));
      bus.disp_base_rdy = 1'($urandom);
      bus.disp_flag_rdy = 1'($urandom);
      bus.disp_base_val = 16'($urandom);
      bus.disp_flag_val = 8'($urandom);
      bus.disp_offset = 8'($urandom);
      bus.disp_immediate = 4'($urandom);
      bus.cdb_valid = 1'($urandom);
      bus.cdb_tag = 6'($urandom_range(0, 7));
      bus.cdb_value = 16'($urandom);
      bus.instr_ready = 1'($urandom);
      flush = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      k = m_sel();
      n_chk++; if ({bus.instr_valid, bus.disp_ready} !== {(k >= 0), (mq.size() < DEPTH)}) begin n_fail++;
        $display("FAIL rand_hs c%0d: got %b want %b", c, {bus.instr_valid, bus.disp_ready}, {(k >= 0), (mq.size() < DEPTH)}); end
      if (k >= 0) begin
        exp_f = {mq[k].op, mq[k].bv, mq[k].fv, mq[k].off, mq[k].imm};
        n_chk++; if ({bus.opcode, bus.reg_base_val, bus.flag_vals, bus.offset, bus.immediate} !== exp_f) begin n_fail++;
          $display("FAIL rand_data c%0d: got %h want %h", c, {bus.opcode, bus.reg_base_val, bus.flag_vals, bus.offset, bus.immediate}, exp_f); end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flag_wakeup();
    test_order();
    test_full();
    test_capture();
    test_flush_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
